// File: rtl/p2p_link_pkg.sv
// ============================================================================
// Module      : p2p_link_pkg
// Description : Shared state encoding, counter width and index-width helper
//               for the point-to-point link arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package p2p_link_pkg;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = IDLE,
    ST_WAIT = WAIT
  } state_t;

  localparam int CNT_W = 4;

  // Index width for owner/last; never below 1 so a 2-client build still has a bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/p2p_rr_pick.sv
// ============================================================================
// Module      : p2p_rr_pick
// Description : Combinational round-robin picker; scans from last+1 upward.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module p2p_rr_pick
  import p2p_link_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [NREQ-1:0]  o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  int w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_cand   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      w_cand = (int'(i_last) + i) % NREQ;
      if (!o_valid && i_req[w_cand]) begin
        o_valid          = 1'b1;
        o_onehot[w_cand] = 1'b1;
        o_idx            = IDX_W'(w_cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/p2p_link_arbiter.sv
// ============================================================================
// Module      : p2p_link_arbiter
// Description : Round-robin sharing of one fixed-latency slave link among
//               NREQ clients; one outstanding transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module p2p_link_arbiter
  import p2p_link_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NREQ    = 4,
  parameter int LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [WIDTH-1:0]      link_tx,
  input  logic [WIDTH-1:0]      link_rx,
  output logic                  busy
);

  localparam int IDX_W = clog2(NREQ);

  state_t             r_state,     w_state_nxt;
  logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
  logic [IDX_W-1:0]   r_owner,     w_owner_nxt;
  logic [IDX_W-1:0]   r_last,      w_last_nxt;
  logic [NREQ-1:0]    r_gnt,       w_gnt_nxt;
  logic [NREQ-1:0]    r_rsp_valid, w_rsp_valid_nxt;
  logic [WIDTH-1:0]   r_rsp_data,  w_rsp_data_nxt;
  logic [WIDTH-1:0]   r_link_tx,   w_link_tx_nxt;

  logic [NREQ-1:0]    w_win_oh;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_win_vld;
  logic [WIDTH-1:0]   w_win_data;

  p2p_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req    (req),
    .i_last   (r_last),
    .o_onehot (w_win_oh),
    .o_idx    (w_win_idx),
    .o_valid  (w_win_vld)
  );

  // One-hot mux keeps every slice index constant.
  always_comb begin
    w_win_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_win_oh[k]) w_win_data = w_win_data | req_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_owner_nxt     = r_owner;
    w_last_nxt      = r_last;
    w_gnt_nxt       = '0;
    w_rsp_valid_nxt = '0;
    w_rsp_data_nxt  = r_rsp_data;
    w_link_tx_nxt   = r_link_tx;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_gnt_nxt     = w_win_oh;
          w_link_tx_nxt = w_win_data;
          w_owner_nxt   = w_win_idx;
          w_last_nxt    = w_win_idx;
          w_cnt_nxt     = CNT_W'(LATENCY);
          w_state_nxt   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_rsp_data_nxt           = link_rx;
          w_rsp_valid_nxt[r_owner] = 1'b1;
          w_state_nxt              = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_owner     <= '0;
      r_last      <= IDX_W'(NREQ - 1);
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_link_tx   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_owner     <= w_owner_nxt;
      r_last      <= w_last_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_link_tx   <= w_link_tx_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign link_tx   = r_link_tx;
  assign busy      = (r_state == ST_WAIT);

endmodule

`default_nettype wire

// File: tb/tb_p2p_link_arbiter.sv
// ============================================================================
// Module      : tb_p2p_link_arbiter
// Description : Two arbiters (LATENCY 1 with registered inverter far end,
//               LATENCY 0 with combinational inverter) against a timestamp model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_p2p_link_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;

  logic [NREQ-1:0]  gnt_a, rv_a, gnt_b, rv_b;
  logic [WIDTH-1:0] rd_a, tx_a, rx_a, rd_b, tx_b, rx_b;
  logic             busy_a, busy_b;

  int n_cmp;
  int n_bad;

  always #5 clock = ~clock;

  p2p_link_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LATENCY(1)) u_dut_a (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt_a), .rsp_valid(rv_a), .rsp_data(rd_a),
    .link_tx(tx_a), .link_rx(rx_a), .busy(busy_a)
  );

  p2p_link_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LATENCY(0)) u_dut_b (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt_b), .rsp_valid(rv_b), .rsp_data(rd_b),
    .link_tx(tx_b), .link_rx(rx_b), .busy(busy_b)
  );

  always @(posedge clock) rx_a <= ~tx_a;
  assign rx_b = ~tx_b;

  // Timestamp model: a grant at edge g books the link until g+L+1, when ~word returns.
  int               cyc;
  int               free_at [2];
  int               due     [2];
  bit               pend    [2];
  int               pown    [2];
  logic [WIDTH-1:0] pdat    [2];
  int               last_m  [2];
  int               win;
  int               lat;
  logic [NREQ-1:0]  e_gnt   [2];
  logic [NREQ-1:0]  e_rv    [2];
  logic [WIDTH-1:0] e_rd    [2];
  logic [WIDTH-1:0] e_tx    [2];
  bit               e_busy  [2];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        free_at[k] = 0; pend[k] = 1'b0; last_m[k] = NREQ - 1;
        e_gnt[k] = '0; e_rv[k] = '0; e_rd[k] = '0; e_tx[k] = '0; e_busy[k] = 1'b0;
      end
    end else begin
      cyc = cyc + 1;
      for (int k = 0; k < 2; k++) begin
        lat      = (k == 0) ? 1 : 0;
        e_gnt[k] = '0;
        e_rv[k]  = '0;
        if (pend[k] && cyc == due[k]) begin
          e_rv[k][pown[k]] = 1'b1;
          e_rd[k]          = ~pdat[k];
          pend[k]          = 1'b0;
        end else if (!pend[k] && cyc >= free_at[k] && req != '0) begin
          win = -1;
          for (int s = 1; s <= NREQ; s++)
            if (win < 0 && req[(last_m[k] + s) % NREQ]) win = (last_m[k] + s) % NREQ;
          e_gnt[k][win] = 1'b1;
          e_tx[k]       = req_data[win*WIDTH +: WIDTH];
          last_m[k]     = win;
          pown[k]       = win;
          pdat[k]       = e_tx[k];
          due[k]        = cyc + lat + 1;
          free_at[k]    = cyc + lat + 2;
          pend[k]       = 1'b1;
        end
        e_busy[k] = pend[k];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clock);
      chk("a_gnt",  32'(gnt_a),  32'(e_gnt[0]));
      chk("a_rv",   32'(rv_a),   32'(e_rv[0]));
      chk("a_rd",   32'(rd_a),   32'(e_rd[0]));
      chk("a_tx",   32'(tx_a),   32'(e_tx[0]));
      chk("a_busy", 32'(busy_a), 32'(e_busy[0]));
      chk("b_gnt",  32'(gnt_b),  32'(e_gnt[1]));
      chk("b_rv",   32'(rv_b),   32'(e_rv[1]));
      chk("b_rd",   32'(rd_b),   32'(e_rd[1]));
      chk("b_tx",   32'(tx_b),   32'(e_tx[1]));
      chk("b_busy", 32'(busy_b), 32'(e_busy[1]));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    req   = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    req      = '0;
    req_data = '0;
    reset    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    fork
      compare_loop();
    join_none

    chk("rst_gnt",  32'(gnt_a),  0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_tx",   32'(tx_a),   0);
    chk("rst_rd",   32'(rd_a),   0);

    // Single client, LATENCY 1
    req = 4'b0001; req_data[0 +: WIDTH] = 16'h1234;
    tick();
    chk("t1_gnt", 32'(gnt_a), 32'h1);
    chk("t1_tx",  32'(tx_a),  32'h1234);
    chk("t1_busy0", 32'(busy_a), 1);
    req = '0;
    tick();
    chk("t1_busy1", 32'(busy_a), 1);
    chk("t1_gnt_off", 32'(gnt_a), 0);
    tick();
    chk("t1_rv",  32'(rv_a),  32'h1);
    chk("t1_rd",  32'(rd_a),  32'hEDCB);
    chk("t1_busy2", 32'(busy_a), 0);
    tick();
    chk("t1_rv_off", 32'(rv_a), 0);
    chk("t1_rd_hold", 32'(rd_a), 32'hEDCB);

    // LATENCY 0 build: transactions every 2 cycles
    req = 4'b0001; req_data[0 +: WIDTH] = 16'h00FF;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("t5_gnt", 32'(gnt_b), (t % 2 == 0) ? 32'h1 : 32'h0);
      if (t % 2 == 1) begin
        chk("t5_rv", 32'(rv_b), 32'h1);
        chk("t5_rd", 32'(rd_b), 32'hFF00);
      end
    end
    req = '0;
    repeat (4) tick();

    // All clients held: round-robin 0,1,2,3,0 every 3 cycles
    do_reset();
    for (int k = 0; k < NREQ; k++) req_data[k*WIDTH +: WIDTH] = 16'hA000 + 16'(k);
    req = 4'b1111;
    for (int t = 0; t < 15; t++) begin
      tick();
      chk("t2_order", 32'(gnt_a), (t % 3 == 0) ? (32'h1 << ((t / 3) % 4)) : 32'h0);
    end
    req = '0;
    repeat (4) tick();

    // Request arriving during WAIT waits for the response
    do_reset();
    req = 4'b0001; req_data[0 +: WIDTH] = 16'h5555;
    tick();
    chk("t3_gnt0", 32'(gnt_a), 32'h1);
    req = 4'b0100; req_data[2*WIDTH +: WIDTH] = 16'h0F0F;
    tick();
    chk("t3_hold", 32'(gnt_a), 0);
    tick();
    chk("t3_rv0", 32'(rv_a), 32'h1);
    chk("t3_nognt", 32'(gnt_a), 0);
    tick();
    chk("t3_gnt2", 32'(gnt_a), 32'h4);
    req = '0;
    tick();
    tick();
    chk("t3_rv2", 32'(rv_a), 32'h4);
    chk("t3_rd2", 32'(rd_a), 32'hF0F0);
    tick();

    // Reset one cycle after a grant drops the transaction
    do_reset();
    req = 4'b0001; req_data[0 +: WIDTH] = 16'h3C3C;
    tick();
    chk("t4_gnt0", 32'(gnt_a), 32'h1);
    req = '0;
    tick();
    reset = 1'b1;
    #1;
    chk("t4_gnt",  32'(gnt_a),  0);
    chk("t4_rv",   32'(rv_a),   0);
    chk("t4_tx",   32'(tx_a),   0);
    chk("t4_busy", 32'(busy_a), 0);
    chk("t4_rd",   32'(rd_a),   0);
    tick();
    reset = 1'b0;
    req = 4'b0010; req_data[1*WIDTH +: WIDTH] = 16'h1111;
    tick();
    chk("t4_gnt1", 32'(gnt_a), 32'h2);
    req = '0;
    tick();
    tick();
    chk("t4_rv1", 32'(rv_a), 32'h2);
    chk("t4_rd1", 32'(rd_a), 32'hEEEE);
    tick();

    // Client 3 withdraws before being granted
    do_reset();
    req = 4'b1010;
    req_data[1*WIDTH +: WIDTH] = 16'h1111;
    req_data[3*WIDTH +: WIDTH] = 16'h3333;
    tick();
    chk("t6_gnt1", 32'(gnt_a), 32'h2);
    req[3] = 1'b0;
    for (int t = 0; t < 9; t++) begin
      tick();
      chk("t6_no3", 32'(gnt_a[3]), 0);
    end
    req = '0;
    repeat (4) tick();

    // Randomised traffic with occasional resets
    for (int n = 0; n < 2000; n++) begin
      tick();
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        req   = '0;
        tick();
        reset = 1'b0;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          if (req[k]) begin
            if (gnt_a[k] || $urandom_range(0, 15) == 0) req[k] = 1'b0;
          end else if ($urandom_range(0, 2) == 0) begin
            req_data[k*WIDTH +: WIDTH] = 16'($urandom);
            req[k] = 1'b1;
          end
        end
      end
    end
    req = '0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/p2p_link_arbiter.md
Name: p2p_link_arbiter

Overview:
- Shares one point-to-point slave link (16-bit word out, 16-bit word back) between NREQ client requesters.
- Grants one requester at a time using round-robin order. Drives the granted word onto the link, waits the far end's fixed latency, then returns the response word to the owner.
- Sits between several local clients and the point_slave_io slot, on the same link clock.

Parameters:
- WIDTH, 16, link and client word width.
- NREQ, 4, number of requesters (2..16).
- LATENCY, 1, register stages in the far end between link_tx and link_rx (0..15).

Ports:
- clock  in  1  link clock, all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-client request. Held by the client until its gnt bit pulses.
- req_data  in  NREQ*WIDTH  client words. Client k occupies bits [k*WIDTH +: WIDTH]. Must be stable while req[k] is high.
- gnt  out  NREQ  one-hot, one-cycle pulse. Marks acceptance of the client's word.
- rsp_valid  out  NREQ  one-hot, one-cycle pulse. rsp_data is valid for that client.
- rsp_data  out  WIDTH  response word, shared by all clients.
- link_tx  out  WIDTH  word driven to the far end (the slot's data_i side).
- link_rx  in  WIDTH  word returned by the far end (the slot's data_o side).
- busy  out  1  high while a transaction is outstanding (state WAIT).

Behaviour:
- Reset (async, any state):
  - state=IDLE, cnt=0, gnt=0, rsp_valid=0, rsp_data=0, link_tx=0, busy=0.
  - last=NREQ-1, so requester 0 wins first after reset.
  - A reset mid-transaction drops the transaction. No rsp_valid is produced for it.
- FSM states: IDLE, WAIT.
- IDLE, on an edge where req!=0:
  - winner = first set req bit scanning last+1, last+2, ... modulo NREQ.
  - gnt[winner]<=1 for one cycle, link_tx<=req_data[winner], owner<=winner, last<=winner.
  - cnt<=LATENCY, state<=WAIT.
- IDLE with req==0: no change. link_tx holds its last value.
- WAIT, each edge:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: rsp_data<=link_rx, rsp_valid[owner]<=1, state<=IDLE.
- Timing:
  - The grant edge is E0. link_rx is sampled at edge E0+LATENCY+1.
  - rsp_valid is high in the cycle after that edge.
  - The next grant can occur at the following edge at the earliest.
  - Throughput: one transaction per LATENCY+2 cycles.
- req changes while in WAIT are ignored. A requester may drop req before being granted; it is then simply not granted.
- gnt, rsp_valid, busy and rsp_data are all registered. No combinational input-to-output paths.
- cnt width is 4 bits. owner and last are clog2(NREQ) bits. last wraps from NREQ-1 to 0.
- A single requester holding req continuously is re-granted every LATENCY+2 cycles.
- rsp_data holds its value after rsp_valid falls, until the next capture.

Decomposition:
- Shared package p2p_link_pkg holds:
  - state encoding localparams (IDLE=0, WAIT=1).
  - CNT_W=4.
  - a clog2 function for the owner/last width.
- Sub-module p2p_rr_pick (combinational): inputs req[NREQ] and last; outputs a one-hot winner and its index.
- The arbiter holds all state, the counter and the link registers.

Test Plan:
Benches use the inverting far end (link_rx <= ~link_tx on posedge, LATENCY=1).
1. Reset then req[0]=1, data 0x1234 → gnt[0] pulses at E0, link_tx=0x1234. rsp_valid[0] and rsp_data=0xEDCB in the cycle after E0+2. busy is high for exactly 2 cycles.
2. req=4'b1111 held with distinct data → grants in order 0,1,2,3,0, spaced 3 cycles apart. Each rsp_data equals the inverse of that owner's word.
3. req[2] asserted during WAIT of client 0 → no grant until after client 0's rsp_valid. Then gnt[2]; client 2 is not skipped by pointer wrap.
4. Reset asserted one cycle after a grant → all outputs 0 immediately. No rsp_valid follows. The next req[1] alone is granted normally with latency unchanged.
5. LATENCY=0 build with a combinational inverter far end, data 0x00FF → rsp_data=0xFF00 with rsp_valid one cycle after the grant edge. Transactions are 2 cycles apart.
6. req[3] pulsed low before being granted while req[1] stays high → only client 1 is granted. gnt[3] never pulses.
